// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tetris_pkg
// Purpose  : Op-code and FSM-state encodings shared by the op scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package tetris_pkg;

    localparam logic [2:0] OP_NONE      = 3'd0;
    localparam logic [2:0] OP_ROT       = 3'd1;
    localparam logic [2:0] OP_LEFT      = 3'd2;
    localparam logic [2:0] OP_RIGHT     = 3'd3;
    localparam logic [2:0] OP_SOFT_DOWN = 3'd4;
    localparam logic [2:0] OP_AUTO_DOWN = 3'd5;

    // Pending-flag bit positions, lowest index wins arbitration
    localparam int c_src_auto  = 0;
    localparam int c_src_soft  = 1;
    localparam int c_src_rot   = 2;
    localparam int c_src_left  = 3;
    localparam int c_src_right = 4;
    localparam int c_num_src   = 5;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_issue = 2'd1;
    localparam logic [1:0] c_st_wait  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/tetris_op_scheduler_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Prescaler producing a 1-cycle tick every TICK_DIV clocks.
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] c_last = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Held at zero while stopped so every restart begins a full period
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_cnt <= '0;
        end else if (!run) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = run && (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/tetris_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tetris_op_scheduler
// Purpose  : Arbitrates key requests and gravity into one datapath op at a
//            time; tracks cleared lines, level and the gravity period.
// Revision : 1.0 - initial release
// ============================================================================
module tetris_op_scheduler
    import tetris_pkg::*;
#(
    parameter int TICK_DIV        = 50000,
    parameter int BASE_PERIOD     = 1000,
    parameter int STEP            = 80,
    parameter int MIN_PERIOD      = 100,
    parameter int LINES_PER_LEVEL = 10,
    parameter int MAX_LEVEL       = 9
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       enable,
    input  logic       start,
    input  logic       rotate,
    input  logic       left,
    input  logic       right,
    input  logic       down,
    input  logic       lines_valid,
    input  logic [2:0] lines_cleared,
    output logic       op_valid,
    output logic [2:0] op_code,
    input  logic       op_ack,
    input  logic       op_done,
    output logic       busy,
    output logic [3:0] level,
    output logic [7:0] lines_total
);

    localparam int PW = $clog2(BASE_PERIOD + 1);
    localparam logic [7:0] c_lines_per_level = 8'(LINES_PER_LEVEL);

    logic [1:0]           r_state;
    logic [1:0]           w_state_next;
    logic [c_num_src-1:0] r_pend;
    logic [c_num_src-1:0] w_set_mask;
    logic [c_num_src-1:0] w_clr_mask;
    logic [c_num_src-1:0] w_grant_oh;
    logic [c_num_src-1:0] r_grant_oh;
    logic [2:0]           w_grant_code;
    logic [2:0]           r_op_code;
    logic                 w_grant;
    logic                 w_ack_fire;
    logic                 w_soft_ack;
    logic                 w_run;
    logic                 w_tick;
    logic                 w_grav_fire;
    logic [PW-1:0]        r_grav_cnt;
    logic [PW-1:0]        r_period;
    logic [PW-1:0]        w_period_next;
    logic signed [31:0]   w_period_s;
    logic [7:0]           r_lines_total;
    logic [8:0]           w_lines_sum;
    logic [7:0]           w_quot;
    logic [3:0]           r_level;
    logic [3:0]           w_level_next;

    assign w_run = enable && !start;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .clr  (clr),
        .run  (w_run),
        .tick (w_tick)
    );

    // ---------------------------------------------------------------- arbiter
    always_comb begin
        w_grant_oh   = '0;
        w_grant_code = OP_NONE;
        if (r_pend[c_src_auto]) begin
            w_grant_oh[c_src_auto] = 1'b1;
            w_grant_code           = OP_AUTO_DOWN;
        end else if (r_pend[c_src_soft]) begin
            w_grant_oh[c_src_soft] = 1'b1;
            w_grant_code           = OP_SOFT_DOWN;
        end else if (r_pend[c_src_rot]) begin
            w_grant_oh[c_src_rot] = 1'b1;
            w_grant_code          = OP_ROT;
        end else if (r_pend[c_src_left]) begin
            w_grant_oh[c_src_left] = 1'b1;
            w_grant_code           = OP_LEFT;
        end else if (r_pend[c_src_right]) begin
            w_grant_oh[c_src_right] = 1'b1;
            w_grant_code            = OP_RIGHT;
        end
    end

    assign w_grant    = enable && (r_state == c_st_idle) && (|r_pend);
    assign w_ack_fire = (r_state == c_st_issue) && op_ack;
    assign w_soft_ack = w_ack_fire && r_grant_oh[c_src_soft];

    // -------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // An ack wins over a simultaneous disable: the datapath already owns the op
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: begin
                if (w_grant) w_state_next = c_st_issue;
            end
            c_st_issue: begin
                if (op_ack)       w_state_next = c_st_wait;
                else if (!enable) w_state_next = c_st_idle;
            end
            c_st_wait: begin
                if (op_done) w_state_next = c_st_idle;
            end
            default: w_state_next = c_st_idle;
        endcase
    end

    always_comb begin
        op_valid = (r_state == c_st_issue);
        busy     = (r_state != c_st_idle);
        op_code  = (r_state == c_st_idle) ? OP_NONE : r_op_code;
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_op_code  <= OP_NONE;
            r_grant_oh <= '0;
        end else if (w_grant) begin
            r_op_code  <= w_grant_code;
            r_grant_oh <= w_grant_oh;
        end
    end

    // ---------------------------------------------------------- pending flags
    always_comb begin
        w_set_mask              = '0;
        w_set_mask[c_src_auto]  = w_grav_fire;
        w_set_mask[c_src_soft]  = down;
        w_set_mask[c_src_rot]   = rotate;
        w_set_mask[c_src_left]  = left && !right;
        w_set_mask[c_src_right] = right && !left;
        w_clr_mask              = w_ack_fire ? r_grant_oh : '0;
    end

    // A fresh pulse landing on the ack cycle survives as a new request
    always_ff @(posedge clk) begin
        if (!clr) begin
            r_pend <= '0;
        end else if (start || !enable) begin
            r_pend <= '0;
        end else begin
            r_pend <= (r_pend & ~w_clr_mask) | w_set_mask;
        end
    end

    // ---------------------------------------------------------------- gravity
    // >= rather than == so a period shrinking below the count still fires
    assign w_grav_fire = enable && !start && w_tick && !r_pend[c_src_auto] &&
                         (r_grav_cnt >= (r_period - PW'(1)));

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_grav_cnt <= '0;
        end else if (start || !enable || w_soft_ack || w_grav_fire) begin
            r_grav_cnt <= '0;
        end else if (w_tick && !r_pend[c_src_auto]) begin
            r_grav_cnt <= r_grav_cnt + PW'(1);
        end
    end

    always_comb begin
        w_period_s = BASE_PERIOD - STEP * $signed({28'd0, r_level});
        if (w_period_s < MIN_PERIOD) begin
            w_period_next = PW'(MIN_PERIOD);
        end else begin
            w_period_next = PW'(w_period_s);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_period <= PW'(BASE_PERIOD);
        end else if (start) begin
            r_period <= PW'(BASE_PERIOD);
        end else begin
            r_period <= w_period_next;
        end
    end

    // ---------------------------------------------------------- lines / level
    always_comb begin
        w_lines_sum  = {1'b0, r_lines_total} + {6'd0, lines_cleared};
        w_quot       = r_lines_total / c_lines_per_level;
        w_level_next = (w_quot > 8'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : w_quot[3:0];
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_lines_total <= '0;
            r_level       <= '0;
        end else if (start) begin
            r_lines_total <= '0;
            r_level       <= '0;
        end else begin
            if (lines_valid) begin
                r_lines_total <= w_lines_sum[8] ? 8'hFF : w_lines_sum[7:0];
            end
            r_level <= w_level_next;
        end
    end

    assign level       = r_level;
    assign lines_total = r_lines_total;

endmodule
`default_nettype wire

// File: tb/tb_tetris_op_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_tetris_op_scheduler
// Purpose  : Directed self-checking bench for tetris_op_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tetris_op_scheduler;

    logic       clk = 1'b0;
    logic       clr;
    logic       enable;
    logic       start;
    logic       rotate;
    logic       left;
    logic       right;
    logic       down;
    logic       lines_valid;
    logic [2:0] lines_cleared;
    logic       op_valid;
    logic [2:0] op_code;
    logic       op_ack;
    logic       op_done;
    logic       busy;
    logic [3:0] level;
    logic [7:0] lines_total;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    tetris_op_scheduler #(
        .TICK_DIV        (4),
        .BASE_PERIOD     (10),
        .STEP            (2),
        .MIN_PERIOD      (4),
        .LINES_PER_LEVEL (2),
        .MAX_LEVEL       (9)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .enable        (enable),
        .start         (start),
        .rotate        (rotate),
        .left          (left),
        .right         (right),
        .down          (down),
        .lines_valid   (lines_valid),
        .lines_cleared (lines_cleared),
        .op_valid      (op_valid),
        .op_code       (op_code),
        .op_ack        (op_ack),
        .op_done       (op_done),
        .busy          (busy),
        .level         (level),
        .lines_total   (lines_total)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int max_cyc, output int code, output int at);
        code = -1;
        at   = -1;
        for (int i = 0; i < max_cyc; i++) begin
            if (op_valid === 1'b1) begin
                code = int'(op_code);
                at   = cyc;
                break;
            end
            step();
        end
    endtask

    task automatic handshake();
        op_ack = 1'b1;
        step();
        op_ack  = 1'b0;
        op_done = 1'b1;
        step();
        op_done = 1'b0;
    endtask

    task automatic toggle_enable();
        enable = 1'b0;
        step();
        enable = 1'b1;
    endtask

    task automatic expect_quiet(input string tag, input int n);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (op_valid === 1'b1) seen++;
            step();
        end
        check(tag, seen, 0);
    endtask

    initial begin
        int code;
        int at;
        int t0;

        clr = 1'b0; enable = 1'b0; start = 1'b0;
        rotate = 1'b0; left = 1'b0; right = 1'b0; down = 1'b0;
        lines_valid = 1'b0; lines_cleared = 3'd0;
        op_ack = 1'b0; op_done = 1'b0;
        step();
        step();
        check("rst_op_valid", op_valid, 0);
        check("rst_op_code", op_code, 0);
        check("rst_busy", busy, 0);
        check("rst_level", level, 0);
        check("rst_lines_total", lines_total, 0);

        // Gravity: 10 ticks x 4 clk; flag set on the 40th edge, offer visible on the next
        clr    = 1'b1;
        enable = 1'b1;
        step();
        t0 = cyc;
        wait_valid(200, code, at);
        check("auto1_delay", at - t0, 40);
        check("auto1_code", code, 5);
        check("auto1_busy", busy, 1);
        handshake();
        check("auto1_idle_busy", busy, 0);
        check("auto1_idle_code", op_code, 0);
        wait_valid(200, code, at);
        check("auto2_delay", at - t0, 80);
        check("auto2_code", code, 5);
        handshake();

        // rotate + down together: SOFT_DOWN wins, ROT follows, each once
        toggle_enable();
        rotate = 1'b1; down = 1'b1;
        step();
        rotate = 1'b0; down = 1'b0;
        wait_valid(20, code, at);
        check("rd_first", code, 4);
        handshake();
        wait_valid(20, code, at);
        check("rd_second", code, 1);
        handshake();
        expect_quiet("rd_no_repeat", 10);

        // left + right together are both dropped
        toggle_enable();
        left = 1'b1; right = 1'b1;
        step();
        left = 1'b0; right = 1'b0;
        expect_quiet("lr_ignored", 10);

        // Three left pulses while a ROT op is held collapse to one LEFT op
        toggle_enable();
        rotate = 1'b1;
        step();
        rotate = 1'b0;
        wait_valid(20, code, at);
        check("merge_rot", code, 1);
        for (int i = 0; i < 3; i++) begin
            left = 1'b1;
            step();
            left = 1'b0;
            step();
        end
        check("merge_rot_stable", op_code, 1);
        check("merge_rot_valid", op_valid, 1);
        handshake();
        wait_valid(20, code, at);
        check("merge_left", code, 2);
        handshake();
        expect_quiet("merge_single", 8);

        // 4 + 4 lines -> level 4 -> period max(10-8,4)=4 ticks = 16 clk
        toggle_enable();
        lines_valid = 1'b1; lines_cleared = 3'd4;
        step();
        step();
        lines_valid = 1'b0; lines_cleared = 3'd0;
        step();
        step();
        check("lines8_total", lines_total, 8);
        check("lines8_level", level, 4);
        wait_valid(200, code, t0);
        check("lvl4_auto_a", code, 5);
        handshake();
        wait_valid(200, code, at);
        check("lvl4_auto_b", code, 5);
        check("lvl4_interval", at - t0, 16);
        handshake();

        // 70 x 4 lines saturates at 255, level caps at 9, period floors at 4
        lines_valid = 1'b1; lines_cleared = 3'd4;
        for (int i = 0; i < 70; i++) step();
        lines_valid = 1'b0; lines_cleared = 3'd0;
        step();
        step();
        step();
        check("sat_total", lines_total, 255);
        check("sat_level", level, 9);
        toggle_enable();
        wait_valid(200, code, t0);
        check("sat_auto_a", code, 5);
        handshake();
        wait_valid(200, code, at);
        check("sat_interval", at - t0, 16);
        handshake();

        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("start_total", lines_total, 0);
        check("start_level", level, 0);

        // Disable during ISSUE drops the offer and the pending flag
        toggle_enable();
        rotate = 1'b1;
        step();
        rotate = 1'b0;
        wait_valid(20, code, at);
        check("dis_rot", code, 1);
        enable = 1'b0;
        step();
        check("dis_valid", op_valid, 0);
        check("dis_busy", busy, 0);
        enable = 1'b1;
        expect_quiet("dis_flushed", 10);

        // clr while waiting for op_done returns everything to reset values
        lines_valid = 1'b1; lines_cleared = 3'd3;
        step();
        lines_valid = 1'b0; lines_cleared = 3'd0;
        rotate = 1'b1;
        step();
        rotate = 1'b0;
        wait_valid(20, code, at);
        op_ack = 1'b1;
        step();
        op_ack = 1'b0;
        check("wait_busy", busy, 1);
        check("wait_lines", lines_total, 3);
        check("wait_level", level, 1);
        clr = 1'b0;
        step();
        check("clr_valid", op_valid, 0);
        check("clr_code", op_code, 0);
        check("clr_busy", busy, 0);
        check("clr_level", level, 0);
        check("clr_lines", lines_total, 0);
        clr = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
